port_frame_rx: RTL and testbench
================================

// Module: port_frame_rx
// PURPOSE
// Receiver stage downstream of coreCommunication. It deserializes the framed serial words that
// coreCommunication drives onto portBus (frame enable) and dataBus (serial data), and checks parity.
// Good words are buffered in a small first-word-fall-through FIFO. Each accepted frame is
// acknowledged on arag, and a frame count is kept in the form consumed as the core set's cycle input.
// PARAMETERS
// WORD_W      23  payload bits per frame (matches pData width)
// FIFO_DEPTH  4   receive FIFO entries; power of 2, >= 2
// PORTS
// fastClk     in   1           sole clock; all logic on posedge
// rst         in   1           synchronous, active-high reset
// portBus     in   1           frame enable, high for the whole frame
// dataBus     in   1           serial data, MSB first, sampled only when bitEn=1
// bitEn       in   1           one-fastClk-cycle bit strobe (medClk rate, fastClk/4)
// rdEn        in   1           pop request
// rdData      out  WORD_W      FIFO head word, valid while empty=0
// empty       out  1           FIFO empty
// full        out  1           FIFO full
// count       out  clog2(D)+1  FIFO occupancy
// arag        out  1           1-cycle pulse: frame accepted into FIFO
// parityErr   out  1           1-cycle pulse: parity failure, word discarded
// frameErr    out  1           1-cycle pulse: framing violation, word discarded
// overflow    out  1           1-cycle pulse: good frame dropped because FIFO full
// cycle       out  16          accepted-frame counter, wraps 0xFFFF->0x0000
// BEHAVIOUR
// - Reset values: rdData=0, empty=1, full=0, count=0, arag/parityErr/frameErr/overflow=0,
//   cycle=0, FSM=IDLE, shreg=0, bitCnt=0. The portBus delay register resets to 1, so a portBus
//   that is still high when reset is released is not seen as a frame start.
// - Frame: portBus rising edge (portBus=1, delayed=0), then WORD_W data bits, then 1 even-parity bit,
//   then portBus falls. Bits count only on bitEn cycles.
// - FSM IDLE: on a portBus rising edge -> DATA, bitCnt=0. bitEn in IDLE is ignored.
// - FSM DATA: each bitEn does shreg={shreg[WORD_W-2:0],dataBus} and bitCnt++. On the bitEn with
//   bitCnt==WORD_W-1 -> PARITY. If portBus=0 in any DATA cycle: frameErr pulse, -> IDLE.
// - FSM PARITY: on bitEn latch parOk = ~(^shreg ^ dataBus), -> STOP. If portBus=0 before that
//   bitEn: frameErr pulse, -> IDLE.
// - FSM STOP: a bitEn while portBus=1 is an extra bit: frameErr pulse, -> WAIT.
//   On portBus=0, exactly one of the following happens, then -> IDLE:
//   * parOk=1 and full=0: push shreg, arag pulse, cycle++.
//   * parOk=1 and full=1: overflow pulse; cycle unchanged.
//   * parOk=0: parityErr pulse.
// - FSM WAIT: stays until portBus=0, then -> IDLE with no further pulse.
// - Latency: pulses are registered one cycle after the decisive portBus/bitEn sample. A pushed
//   word appears on rdData, with empty=0, in the same cycle as arag.
// - FIFO: first-word fall-through; a pop occurs when rdEn=1 and empty=0. rdEn on empty is ignored.
//   Push is qualified by full as registered at the start of the cycle; a pop in the same cycle does
//   not free space for the push (full+pop+good frame -> overflow). Push+pop when not full: count unchanged.
// - Pointers wrap modulo FIFO_DEPTH. full=(count==FIFO_DEPTH), empty=(count==0).
// - Reset mid-frame: abort silently, FIFO flushed, no error pulse.
// TESTING
// - Good frame, 0x2AAAAA (11 ones) + parity 1 -> arag x1, rdData=0x2AAAAA, count=1, cycle=1.
// - Same word with parity 0 -> parityErr x1, no arag, count=0, cycle=0.
// - portBus drops after 10 data bits -> frameErr x1, FSM=IDLE. Next good frame is accepted normally.
// - 5 good frames with no rdEn, D=4 -> arag x4, overflow on the 5th, full=1.
//   Then 4 pops return the words in order and empty=1.
// - Full FIFO, rdEn asserted in the same cycle a good frame ends -> overflow, count=3 afterwards.
// - cycle preloaded to 0xFFFF via 65535 frames (or a forced value) + 1 good frame -> cycle=0x0000.
//   rst mid-DATA -> all outputs at reset values, and no frame is seen while portBus stays high.

Source files
------------

// File: rtl/port_frame_rx.sv
// port_frame_rx: receives framed serial words, checks even parity, buffers good
// words in a first-word-fall-through FIFO and counts accepted frames.
module port_frame_rx #(
  parameter int WORD_W     = 23,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          fastClk,
  input  logic                          rst,
  input  logic                          portBus,
  input  logic                          dataBus,
  input  logic                          bitEn,
  input  logic                          rdEn,
  output logic [WORD_W-1:0]             rdData,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          arag,
  output logic                          parityErr,
  output logic                          frameErr,
  output logic                          overflow,
  output logic [15:0]                   cycle
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(WORD_W);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, WAIT} rxStateT;

  rxStateT            stateReg, stateNext;
  logic [WORD_W-1:0]  shregReg, shregNext;
  logic [BIT_W-1:0]   bitCntReg, bitCntNext;
  logic               parOkReg, parOkNext;
  logic               portBusDlyReg;

  // Frame outcome decisions, valid for one cycle
  logic               goodFrame;
  logic               badParity;
  logic               frameFail;

  // FIFO storage and bookkeeping
  logic [WORD_W-1:0]  memReg [FIFO_DEPTH];
  logic [PTR_W-1:0]   wrPtrReg, rdPtrReg, rdPtrInc;
  logic [CNT_W-1:0]   countReg;
  logic [WORD_W-1:0]  rdDataReg, rdDataNext;
  logic [FIFO_DEPTH-1:0] wrSel;
  logic               pushEn, popEn;

  // Pulse outputs and frame counter
  logic               aragReg, parityErrReg, frameErrReg, overflowReg;
  logic [15:0]        cycleReg;

  assign full     = (countReg == DEPTH_CNT);
  assign empty    = (countReg == '0);
  assign count    = countReg;
  assign rdData   = rdDataReg;
  assign arag     = aragReg;
  assign parityErr = parityErrReg;
  assign frameErr = frameErrReg;
  assign overflow = overflowReg;
  assign cycle    = cycleReg;

  // Push uses full as registered at the start of the cycle; a same-cycle pop does not make room
  assign pushEn   = goodFrame & ~full;
  assign popEn    = rdEn & ~empty;
  assign rdPtrInc = rdPtrReg + PTR_W'(1);

  // Receiver state, shift register and portBus edge-detect registers
  always_ff @(posedge fastClk) begin
    if (rst) begin
      stateReg      <= IDLE;
      shregReg      <= '0;
      bitCntReg     <= '0;
      parOkReg      <= 1'b0;
      portBusDlyReg <= 1'b1;  // a portBus held high through reset is not a frame start
    end else begin
      stateReg      <= stateNext;
      shregReg      <= shregNext;
      bitCntReg     <= bitCntNext;
      parOkReg      <= parOkNext;
      portBusDlyReg <= portBus;
    end
  end

  // Next-state logic and frame outcome decisions
  always_comb begin
    stateNext  = stateReg;
    shregNext  = shregReg;
    bitCntNext = bitCntReg;
    parOkNext  = parOkReg;
    goodFrame  = 1'b0;
    badParity  = 1'b0;
    frameFail  = 1'b0;
    case (stateReg)
      IDLE: begin
        if (portBus && !portBusDlyReg) begin
          stateNext  = DATA;
          bitCntNext = '0;
        end
      end
      DATA: begin
        if (!portBus) begin
          frameFail = 1'b1;
          stateNext = IDLE;
        end else if (bitEn) begin
          shregNext  = {shregReg[WORD_W-2:0], dataBus};
          bitCntNext = bitCntReg + BIT_W'(1);
          if (bitCntReg == LAST_BIT) stateNext = PARITY;
        end
      end
      PARITY: begin
        if (!portBus) begin
          frameFail = 1'b1;
          stateNext = IDLE;
        end else if (bitEn) begin
          parOkNext = ~(^shregReg ^ dataBus);
          stateNext = STOP;
        end
      end
      STOP: begin
        if (!portBus) begin
          if (parOkReg) goodFrame = 1'b1;
          else          badParity = 1'b1;
          stateNext = IDLE;
        end else if (bitEn) begin
          frameFail = 1'b1;  // bit strobe after the parity bit: frame too long
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (!portBus) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // One-hot write select per FIFO entry
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : gWrSel
      assign wrSel[gi] = pushEn && (wrPtrReg == PTR_W'(gi));
    end
  endgenerate

  // FIFO storage writes; contents need no reset since occupancy gates reads
  always_ff @(posedge fastClk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (wrSel[i]) memReg[i] <= shregReg;
    end
  end

  // Head-of-FIFO register: next head after a pop, or the pushed word when it becomes head
  always_comb begin
    rdDataNext = rdDataReg;
    if (popEn && (countReg > CNT_W'(1))) begin
      rdDataNext = memReg[rdPtrInc];
    end else if (pushEn && (empty || popEn)) begin
      rdDataNext = shregReg;
    end
  end

  // FIFO pointers, occupancy and head register
  always_ff @(posedge fastClk) begin
    if (rst) begin
      wrPtrReg  <= '0;
      rdPtrReg  <= '0;
      countReg  <= '0;
      rdDataReg <= '0;
    end else begin
      rdDataReg <= rdDataNext;
      if (pushEn) wrPtrReg <= wrPtrReg + PTR_W'(1);
      if (popEn)  rdPtrReg <= rdPtrInc;
      if (pushEn && !popEn)      countReg <= countReg + CNT_W'(1);
      else if (!pushEn && popEn) countReg <= countReg - CNT_W'(1);
    end
  end

  // Registered status pulses and accepted-frame counter
  always_ff @(posedge fastClk) begin
    if (rst) begin
      aragReg      <= 1'b0;
      parityErrReg <= 1'b0;
      frameErrReg  <= 1'b0;
      overflowReg  <= 1'b0;
      cycleReg     <= '0;
    end else begin
      aragReg      <= pushEn;
      parityErrReg <= badParity;
      frameErrReg  <= frameFail;
      overflowReg  <= goodFrame & full;
      if (pushEn) cycleReg <= cycleReg + 16'd1;
    end
  end

endmodule

// File: tb/tb_port_frame_rx.sv
// tb_port_frame_rx: randomized frames against a queue-based reference model of port_frame_rx.
module tb_port_frame_rx;

  localparam int WORD_W = 23;
  localparam int DEPTH  = 4;

  logic              fastClk = 1'b0;
  logic              rst;
  logic              portBus, dataBus, bitEn, rdEn;
  logic [WORD_W-1:0] rdData;
  logic              empty, full;
  logic [2:0]        count;
  logic              arag, parityErr, frameErr, overflow;
  logic [15:0]       cycle;

  port_frame_rx #(.WORD_W(WORD_W), .FIFO_DEPTH(DEPTH)) dut (
    .fastClk(fastClk), .rst(rst), .portBus(portBus), .dataBus(dataBus),
    .bitEn(bitEn), .rdEn(rdEn), .rdData(rdData), .empty(empty), .full(full),
    .count(count), .arag(arag), .parityErr(parityErr), .frameErr(frameErr),
    .overflow(overflow), .cycle(cycle)
  );

  always #5 fastClk = ~fastClk;

  int checks = 0;
  int failures = 0;
  int nArag = 0, nPar = 0, nFrm = 0, nOvf = 0;
  int frameNo = 0;

  // Reference model: FIFO contents and accepted-frame counter
  logic [WORD_W-1:0] q[$];
  logic [15:0]       expCycle = 16'd0;

  // Pulse monitor
  always @(negedge fastClk) begin
    if (arag)      nArag++;
    if (parityErr) nPar++;
    if (frameErr)  nFrm++;
    if (overflow)  nOvf++;
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkState();
    checkEq("count", 32'(count), 32'(q.size()));
    checkEq("empty", 32'(empty), 32'(q.size() == 0));
    checkEq("full",  32'(full),  32'(q.size() == DEPTH));
    checkEq("cycle", 32'(cycle), 32'(expCycle));
    if (q.size() > 0) checkEq("rdData", 32'(rdData), 32'(q[0]));
  endtask

  task automatic bitStrobe(input logic b);
    repeat (3) @(negedge fastClk);
    dataBus = b;
    bitEn   = 1'b1;
    @(negedge fastClk);
    bitEn   = 1'b0;
  endtask

  // nBits counts serial bits sent including parity: 24 = complete frame
  task automatic runFrame(input logic [WORD_W-1:0] w, input int nBits, input logic par,
                          input logic popAtEnd);
    int a0, p0, f0, o0;
    int expA, expP, expF, expO;
    bit fullStart;
    logic b;
    a0 = nArag; p0 = nPar; f0 = nFrm; o0 = nOvf;
    expA = 0; expP = 0; expF = 0; expO = 0;
    fullStart = (q.size() == DEPTH);
    if (nBits != WORD_W + 1)  expF = 1;
    else if (par != (^w))     expP = 1;
    else if (fullStart)       expO = 1;
    else                      expA = 1;

    @(negedge fastClk);
    portBus = 1'b1;
    for (int i = 0; i < nBits; i++) begin
      if (i < WORD_W)       b = w[WORD_W-1-i];
      else if (i == WORD_W) b = par;
      else                  b = 1'($urandom);
      bitStrobe(b);
    end
    repeat (2) @(negedge fastClk);
    if (popAtEnd && q.size() > 0) checkEq("endPopHead", 32'(rdData), 32'(q[0]));
    portBus = 1'b0;
    rdEn    = popAtEnd;
    @(negedge fastClk);
    rdEn    = 1'b0;

    if (popAtEnd && q.size() > 0) void'(q.pop_front());
    if (expA == 1) begin
      q.push_back(w);
      expCycle = expCycle + 16'd1;
    end
    repeat (3) @(negedge fastClk);

    checkEq("aragPulses",   32'(nArag - a0), 32'(expA));
    checkEq("parErrPulses", 32'(nPar - p0),  32'(expP));
    checkEq("frmErrPulses", 32'(nFrm - f0),  32'(expF));
    checkEq("ovfPulses",    32'(nOvf - o0),  32'(expO));
    checkState();
    frameNo++;
    $display("frame %0d word=0x%06h bits=%0d par=%0d pop=%0d -> arag=%0d perr=%0d ferr=%0d ovf=%0d count=%0d cycle=0x%04h",
             frameNo, w, nBits, par, popAtEnd, nArag - a0, nPar - p0, nFrm - f0, nOvf - o0,
             count, cycle);
  endtask

  task automatic popOne();
    if (q.size() > 0) checkEq("popHead", 32'(rdData), 32'(q[0]));
    @(negedge fastClk);
    rdEn = 1'b1;
    @(negedge fastClk);
    rdEn = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    checkState();
    $display("pop -> count=%0d empty=%0d", count, empty);
  endtask

  task automatic goodFrame(input logic [WORD_W-1:0] w, input logic popAtEnd);
    runFrame(w, WORD_W + 1, ^w, popAtEnd);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, p0;
    logic [WORD_W-1:0] w;
    int kind;

    rst = 1'b1; portBus = 1'b0; dataBus = 1'b0; bitEn = 1'b0; rdEn = 1'b0;
    repeat (3) @(negedge fastClk);
    checkEq("rstRdData", 32'(rdData), 32'd0);
    checkEq("rstEmpty",  32'(empty),  32'd1);
    checkEq("rstFull",   32'(full),   32'd0);
    checkEq("rstCount",  32'(count),  32'd0);
    checkEq("rstPulses", 32'({arag, parityErr, frameErr, overflow}), 32'd0);
    checkEq("rstCycle",  32'(cycle),  32'd0);
    rst = 1'b0;
    repeat (2) @(negedge fastClk);

    // Good frame, bad parity, truncated frame, then normal recovery
    runFrame(23'h2AAAAA, 24, 1'b1, 1'b0);
    popOne();
    runFrame(23'h2AAAAA, 24, 1'b0, 1'b0);
    runFrame(23'h155555, 10, 1'b0, 1'b0);
    goodFrame(23'h123456, 1'b0);
    popOne();

    // Overfill: five frames into a four-deep FIFO, then drain in order
    for (int i = 0; i < 5; i++) goodFrame(23'(32'h10000 * (i + 1) + i), 1'b0);
    for (int i = 0; i < 4; i++) popOne();
    popOne();  // pop on empty is ignored

    // Full FIFO with a pop in the same cycle a good frame ends
    for (int i = 0; i < 4; i++) goodFrame(23'(32'h7A000 + i), 1'b0);
    goodFrame(23'h7FFFFF, 1'b1);
    while (q.size() > 0) popOne();

    // Frame counter wrap
    @(negedge fastClk);
    force dut.cycleReg = 16'hFFFF;
    @(negedge fastClk);
    release dut.cycleReg;
    expCycle = 16'hFFFF;
    goodFrame(23'h0F0F0F, 1'b0);
    popOne();

    // Randomized frames, pops and stray bit strobes while idle
    for (int t = 0; t < 40; t++) begin
      w = 23'($urandom);
      kind = $urandom_range(0, 9);
      case (kind)
        6:       runFrame(w, 24, ~(^w), ($urandom_range(0, 3) == 0));
        7:       runFrame(w, $urandom_range(0, 23), 1'($urandom), ($urandom_range(0, 3) == 0));
        8:       runFrame(w, 25, ^w, ($urandom_range(0, 3) == 0));
        9:       goodFrame(w, 1'b1);
        default: goodFrame(w, ($urandom_range(0, 3) == 0));
      endcase
      if ($urandom_range(0, 1) == 1) bitStrobe(1'($urandom));
      for (int k = $urandom_range(0, 2); k > 0; k--) popOne();
    end

    // Reset in the middle of a frame, with portBus still high afterwards
    goodFrame(23'h3C3C3C, 1'b0);
    @(negedge fastClk);
    portBus = 1'b1;
    for (int i = 0; i < 10; i++) bitStrobe(1'($urandom));
    n0 = nFrm + nPar + nArag + nOvf;
    @(negedge fastClk);
    rst = 1'b1;
    repeat (2) @(negedge fastClk);
    rst = 1'b0;
    q.delete();
    expCycle = 16'd0;
    checkEq("midRstRdData", 32'(rdData), 32'd0);
    checkEq("midRstPulses", 32'({arag, parityErr, frameErr, overflow}), 32'd0);
    checkState();
    for (int i = 0; i < 14; i++) bitStrobe(1'($urandom));
    repeat (2) @(negedge fastClk);
    portBus = 1'b0;
    repeat (4) @(negedge fastClk);
    p0 = nFrm + nPar + nArag + nOvf;
    checkEq("midRstNoPulse", 32'(p0 - n0), 32'd0);
    checkState();
    $display("reset mid-frame -> count=%0d cycle=0x%04h", count, cycle);
    goodFrame(23'h5A5A5A, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
